// File: rtl/branch_resolve_predict.sv
// ID-stage branch condition resolver with a PC-indexed BHT of saturating counters,
// mispredict detection against the carried prediction, and saturating branch statistics.
module branch_resolve_predict #(
    parameter int ISA_WIDTH = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 2,
    parameter int STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic [ISA_WIDTH-1:0] if_pc,
    output logic                 predict_taken,
    input  logic                 id_valid,
    input  logic                 id_branch,
    input  logic [ISA_WIDTH-1:0] id_pc,
    input  logic                 id_predicted_taken,
    input  logic [2:0]           condition_type,
    input  logic [ISA_WIDTH-1:0] read_data_1,
    input  logic [ISA_WIDTH-1:0] read_data_2,
    output logic                 condition_result,
    output logic                 mispredict,
    output logic [STAT_W-1:0]    branch_count,
    output logic [STAT_W-1:0]    mispredict_count
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    // Weakly-not-taken: MSB clear, all lower bits set (0 when CNT_W is 1).
    localparam int WEAK_NT_I = (1 << (CNT_W - 1)) - 1;
    localparam logic [CNT_W-1:0] WEAK_NT = WEAK_NT_I[CNT_W-1:0];

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
        return (&s) ? s : s + STAT_W'(1);
    endfunction

    logic [CNT_W-1:0]  bht_q [BHT_DEPTH];
    logic [CNT_W-1:0]  bht_d [BHT_DEPTH];
    logic [STAT_W-1:0] branch_count_q, branch_count_d;
    logic [STAT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] if_idx, id_idx;
    logic             rs_neg, rs_zero, upd;
    logic             unused_pc_bits;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign id_idx  = id_pc[IDX_W+1:2];
    assign rs_neg  = read_data_1[ISA_WIDTH-1];
    assign rs_zero = (read_data_1 == '0);
    assign unused_pc_bits = ^{if_pc[ISA_WIDTH-1:IDX_W+2], if_pc[1:0],
                              id_pc[ISA_WIDTH-1:IDX_W+2], id_pc[1:0]};

    always_comb begin
        condition_result = 1'b0;
        case (condition_type)
            3'b000: condition_result = (read_data_1 == read_data_2);
            3'b001: condition_result = (read_data_1 != read_data_2);
            3'b010: condition_result = rs_neg | rs_zero;
            3'b011: condition_result = ~rs_neg & ~rs_zero;
            3'b100: condition_result = rs_neg;
            3'b101: condition_result = ~rs_neg;
            3'b110: condition_result = 1'b1;
            default: condition_result = 1'b0;
        endcase
    end

    assign mispredict    = id_valid & id_branch & (condition_result != id_predicted_taken);
    assign upd           = id_valid & id_branch & ~stall;
    // Lookup reads the registered table only, so a same-index write shows next cycle.
    assign predict_taken = bht_q[if_idx][CNT_W-1];

    always_comb begin
        bht_d              = bht_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd) begin
            bht_d[id_idx]  = condition_result ? cnt_inc(bht_q[id_idx]) : cnt_dec(bht_q[id_idx]);
            branch_count_d = stat_inc(branch_count_q);
            if (mispredict) begin
                mispredict_count_d = stat_inc(mispredict_count_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= WEAK_NT;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            bht_q              <= bht_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_resolve_predict.sv
// Directed bench for branch_resolve_predict: stimulus queues expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_resolve_predict;
    localparam int ISA_WIDTH = 32;
    localparam int STAT_W    = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 stall;
    logic [ISA_WIDTH-1:0] if_pc;
    logic                 predict_taken;
    logic                 id_valid;
    logic                 id_branch;
    logic [ISA_WIDTH-1:0] id_pc;
    logic                 id_predicted_taken;
    logic [2:0]           condition_type;
    logic [ISA_WIDTH-1:0] read_data_1;
    logic [ISA_WIDTH-1:0] read_data_2;
    logic                 condition_result;
    logic                 mispredict;
    logic [STAT_W-1:0]    branch_count;
    logic [STAT_W-1:0]    mispredict_count;

    branch_resolve_predict #(
        .ISA_WIDTH(ISA_WIDTH), .BHT_DEPTH(16), .CNT_W(2), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .if_pc(if_pc),
        .predict_taken(predict_taken), .id_valid(id_valid), .id_branch(id_branch),
        .id_pc(id_pc), .id_predicted_taken(id_predicted_taken),
        .condition_type(condition_type), .read_data_1(read_data_1),
        .read_data_2(read_data_2), .condition_result(condition_result),
        .mispredict(mispredict), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    localparam int S_PRED = 0, S_COND = 1, S_MISP = 2, S_BC = 3, S_MC = 4;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] dut_val(input int sel);
        case (sel)
            S_PRED:  return {31'd0, predict_taken};
            S_COND:  return {31'd0, condition_result};
            S_MISP:  return {31'd0, mispredict};
            S_BC:    return {28'd0, branch_count};
            default: return {28'd0, mispredict_count};
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            chk_t    c;
            logic [31:0] act;
            c   = exp_q.pop_front();
            act = dut_val(c.sel);
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", c.name, act, c.exp);
            end
        end
    end

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        exp_q.push_back(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [31:0] pc, input logic [2:0] ct, input logic pred);
        id_valid           = 1'b1;
        id_branch          = 1'b1;
        id_pc              = pc;
        condition_type     = ct;
        id_predicted_taken = pred;
    endtask

    logic [7:0] exp_ff, exp_5, exp_0;

    initial begin
        rst_n = 1'b0; stall = 1'b0; if_pc = '0; id_valid = 1'b0; id_branch = 1'b0;
        id_pc = '0; id_predicted_taken = 1'b0; condition_type = 3'b000;
        read_data_1 = '0; read_data_2 = '0;
        cyc();
        cyc();
        rst_n = 1'b1;

        // Reset state: every index predicts not-taken, stats zero.
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            push($sformatf("reset_pred_idx%0d", i), S_PRED, 0);
            if (i == 0) begin
                push("reset_branch_count", S_BC, 0);
                push("reset_mispredict_count", S_MC, 0);
            end
            cyc();
        end

        // Condition sweep with no update in flight.
        exp_ff = 8'b0101_0101;  // bit k = expected result for type k
        read_data_1 = 32'hFFFF_FFFF; read_data_2 = 32'hFFFF_FFFF;
        for (int t = 0; t < 8; t++) begin
            condition_type = 3'(t);
            push($sformatf("cond_allones_type%0d", t), S_COND, {31'd0, exp_ff[t]});
            cyc();
        end
        exp_5 = 8'b0010_1000;
        exp_0 = 8'b0010_0100;
        read_data_2 = 32'd0;
        for (int t = 2; t < 6; t++) begin
            read_data_1 = 32'd5;
            condition_type = 3'(t);
            push($sformatf("cond_rs5_type%0d", t), S_COND, {31'd0, exp_5[t]});
            cyc();
            read_data_1 = 32'd0;
            push($sformatf("cond_rs0_type%0d", t), S_COND, {31'd0, exp_0[t]});
            cyc();
        end

        // Training at 0x40 with ALWAYS; first cycle also checks same-cycle lookup.
        if_pc = 32'h40;
        branch(32'h40, 3'b110, 1'b0);
        push("train_same_cycle_old", S_PRED, 0);
        push("train_first_mispredict", S_MISP, 1);
        cyc();
        id_predicted_taken = 1'b1;
        push("train_after_1_new", S_PRED, 1);
        push("train_no_mispredict", S_MISP, 0);
        push("train_bc1", S_BC, 1);
        push("train_mc1", S_MC, 1);
        cyc();
        push("train_after_2", S_PRED, 1);
        push("train_bc2", S_BC, 2);
        cyc();
        id_valid = 1'b0;
        if_pc = 32'h80;
        push("alias_0x80", S_PRED, 1);
        push("train_bc3", S_BC, 3);
        push("train_mc_still1", S_MC, 1);
        cyc();
        if_pc = 32'h44;
        push("neighbor_0x44", S_PRED, 0);
        cyc();

        // Two not-taken updates from a saturated 11 leave it at 01.
        if_pc = 32'h40;
        branch(32'h40, 3'b111, 1'b1);
        push("dec_from_11", S_PRED, 1);
        push("dec_mispredict", S_MISP, 1);
        cyc();
        push("dec_from_10", S_PRED, 1);
        cyc();
        id_valid = 1'b0;
        push("dec_to_01", S_PRED, 0);
        push("dec_bc5", S_BC, 5);
        push("dec_mc3", S_MC, 3);
        cyc();

        // Mispredict on BEQ taken, then the same with stall asserted.
        read_data_1 = 32'd7; read_data_2 = 32'd7;
        if_pc = 32'h10;
        branch(32'h10, 3'b000, 1'b0);
        push("beq_mispredict", S_MISP, 1);
        cyc();
        stall = 1'b1;
        push("stall_mispredict_comb", S_MISP, 1);
        push("beq_mc4", S_MC, 4);
        push("beq_bc6", S_BC, 6);
        push("beq_trained_pred", S_PRED, 1);
        cyc();
        id_valid = 1'b0;
        push("stall_bc_hold", S_BC, 6);
        push("stall_mc_hold", S_MC, 4);
        cyc();
        stall = 1'b0;
        branch(32'h10, 3'b001, 1'b0);
        push("bne_correct_no_misp", S_MISP, 0);
        push("bne_pre_update", S_PRED, 1);
        cyc();
        id_valid = 1'b0;
        push("stall_blocked_bht", S_PRED, 0);
        push("bne_bc7", S_BC, 7);
        push("bne_mc4", S_MC, 4);
        cyc();

        // Non-branch instruction: no mispredict, no count.
        branch(32'h10, 3'b000, 1'b0);
        id_branch = 1'b0;
        push("nonbranch_no_misp", S_MISP, 0);
        cyc();
        id_valid = 1'b0;
        push("nonbranch_bc_hold", S_BC, 7);
        cyc();

        // Statistics saturation with a 4-bit counter.
        if_pc = 32'h20;
        branch(32'h20, 3'b110, 1'b1);
        for (int k = 0; k < 20; k++) cyc();
        id_valid = 1'b0;
        push("sat_bc15", S_BC, 15);
        push("sat_mc4", S_MC, 4);
        push("sat_pred_0x20", S_PRED, 1);
        cyc();

        // Reset with an update pending: reset wins.
        rst_n = 1'b0;
        branch(32'h20, 3'b110, 1'b0);
        cyc();
        rst_n = 1'b1;
        id_valid = 1'b0;
        push("rst_pred_0x20", S_PRED, 0);
        push("rst_bc0", S_BC, 0);
        push("rst_mc0", S_MC, 0);
        cyc();
        branch(32'h20, 3'b110, 1'b1);
        cyc();
        id_valid = 1'b0;
        push("rst_bht_weak_nt", S_PRED, 1);
        push("rst_bc1", S_BC, 1);
        cyc();

        cyc();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d checks left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolve_predict.md
# branch_resolve_predict

Parametrised successor to the ID-stage branch condition check. It resolves six MIPS branch conditions plus always/never. A BHT of saturating counters, indexed by PC, supplies a taken/not-taken prediction to IF. The block compares that prediction against the ID-stage outcome to raise `mispredict`, trains the counters, and keeps saturating branch and mispredict statistics.

## Interface
- `ISA_WIDTH`, default 32: data and PC width.
- `BHT_DEPTH`, default 16: number of counters; power of 2, at least 2. `IDX_W` = log2(`BHT_DEPTH`).
- `CNT_W`, default 2: counter width, at least 1.
- `STAT_W`, default 16: statistics counter width.
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous reset, active low.
- `stall`  in  1  pipeline stall; blocks every state update.
- `if_pc`  in  `ISA_WIDTH`  PC being fetched.
- `predict_taken`  out  1  combinational prediction for `if_pc`.
- `id_valid`  in  1  ID-stage instruction valid.
- `id_branch`  in  1  ID-stage instruction is a conditional branch.
- `id_pc`  in  `ISA_WIDTH`  PC of the ID-stage instruction.
- `id_predicted_taken`  in  1  prediction carried down the pipe with the instruction.
- `condition_type`  in  3  condition select.
- `read_data_1`, `read_data_2`  in  `ISA_WIDTH` each  rs and rt values, already forwarded.
- `condition_result`  out  1  resolved outcome, combinational.
- `mispredict`  out  1  combinational; driven by `id_valid & id_branch & (condition_result != id_predicted_taken)`.
- `branch_count`  out  `STAT_W`  registered count of resolved branches.
- `mispredict_count`  out  `STAT_W`  registered count of mispredicts.

## Operation
- `condition_type` encoding:
  - 000 BEQ: rs == rt.
  - 001 BNE: rs != rt.
  - 010 BLEZ: rs ≤ 0, signed.
  - 011 BGTZ: rs > 0, signed.
  - 100 BLTZ: rs < 0, i.e. rs MSB = 1.
  - 101 BGEZ: rs ≥ 0.
  - 110 ALWAYS: 1.
  - 111 NEVER: 0.
- `read_data_2` is ignored for types 010–111.
- `condition_result` is fully defined for every encoding. No latches: default 0.
- Index function: `idx(pc) = pc[IDX_W+1:2]`. Word-aligned; the low 2 bits are ignored.
- `predict_taken` = MSB of `bht[idx(if_pc)]`.
- Update condition `upd = id_valid & id_branch & ~stall`. On a clock edge with `upd` high:
  - `bht[idx(id_pc)]` increments if `condition_result` = 1, saturating at 2^CNT_W−1.
  - Otherwise it decrements, saturating at 0.
- On a clock edge with `upd` high, `branch_count` +1, saturating at all-ones.
- On a clock edge with `upd & mispredict` high, `mispredict_count` +1, saturating at all-ones.
- With `stall` high, nothing changes. `condition_result`, `mispredict` and `predict_taken` still track their inputs combinationally.
- `id_branch` low, or `id_valid` low: no update, and `mispredict` = 0.
- Reset (`rst_n` = 0 at an edge):
  - every BHT entry is set to weakly-not-taken, 2^(CNT_W−1)−1. For `CNT_W` = 1 this is 0.
  - both statistics counters are set to 0.
  - Consequence: `predict_taken` = 0 after reset for every PC.
- Reset has priority over `upd` in the same cycle.
- Simultaneous read and write to the same index: `predict_taken` returns the pre-update value. There is no bypass; the new value is visible from the next cycle.

## Timing
- Combinational, zero cycles: `condition_result`, `mispredict`, `predict_taken`.
- BHT and statistics updates take effect at the rising edge where `upd` is sampled. They are visible one cycle later.
- `mispredict` is used by the hazard unit to flush IF in the same cycle. The block does not register it.
- Reset mid-run discards all training. Outputs read the reset values one cycle after the reset edge.
- Statistics counters never wrap.

## Test plan
- Reset, then sweep `if_pc` across all `BHT_DEPTH` indices -> `predict_taken` = 0 everywhere; `branch_count` = `mispredict_count` = 0.
- Condition sweep:
  - rs = 0xFFFFFFFF, rt = 0xFFFFFFFF for types 000–111 -> results 1,0,1,0,1,0,1,0.
  - rs = 5 for types 010–101 -> results 0,1,0,1.
  - rs = 0 for types 010–101 -> results 1,0,0,1.
- Training at pc = 0x40, starting from reset:
  - three taken updates -> counter goes 01→10→11→11.
  - `predict_taken` at 0x40 becomes 1 after the first update.
  - `predict_taken` at pc = 0x80, which aliases at `BHT_DEPTH` = 16, also becomes 1.
  - `predict_taken` at pc = 0x44 stays 0.
- Mispredict: `id_predicted_taken` = 0 and BEQ with equal operands -> `mispredict` = 1 in the same cycle; `mispredict_count` = 1 on the next cycle. Repeat with `stall` = 1 -> `mispredict` = 1 but both counters unchanged.
- Same-cycle update and lookup on one index -> `predict_taken` shows the old value in that cycle and the new value in the next.
- Force `STAT_W` = 4 and run 20 branches -> `branch_count` holds at 15. Assert `rst_n` = 0 with `upd` high -> counters return to 0 and the BHT to 01.
